// File: rtl/mdio_master_gen.sv
// mdio_master_gen
//   MDIO management master with a command queue. Frames pushed on T_DATA are
//   queued and then sent one at a time. Each frame is sent as PRE_LEN
//   preamble ones followed by the 32 frame bits, MSB first. MDC is generated
//   from clk. For read opcodes the MDIO line is released from turnaround
//   onwards, and the 16 data bits from the PHY are captured into RD_DATA.
//
// Parameters
//   DIV      MDC half-period in clk cycles (>=1); one MDIO bit = 2*DIV clk
//   PRE_LEN  preamble length in bits (0..32)
//   QDEPTH   command queue depth (power of two, >=2)
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   T_DATA, MDIO_START frame word and its push strobe
//   CMD_READY, Q_LEVEL queue not full, queue occupancy
//   BUSY               a frame is in progress
//   MDIO_IN            MDIO pad input (already synchronised outside)
//   RD_DATA, DATA_RDY  last read data and its one-clk update pulse
//   MDC, MDIO_OE, MDIO_OUT  management clock and MDIO pad drive
module mdio_master_gen #(
  parameter int DIV     = 2,
  parameter int PRE_LEN = 32,
  parameter int QDEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                T_DATA,
  input  logic                       MDIO_START,
  output logic                       CMD_READY,
  output logic [$clog2(QDEPTH):0]    Q_LEVEL,
  output logic                       BUSY,
  input  logic                       MDIO_IN,
  output logic [15:0]                RD_DATA,
  output logic                       DATA_RDY,
  output logic                       MDC,
  output logic                       MDIO_OE,
  output logic                       MDIO_OUT
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(2 * DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV - 1);
  localparam logic [CW-1:0] FULL = CW'(2 * DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PRE, HDR, TA, DATA, DONE} state_t;

  // ---------------- command queue ----------------
  logic [31:0] mem [QDEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          push, pop;
  logic [31:0]   head;
  state_t        state_reg;

  assign push      = MDIO_START && CMD_READY;
  assign pop       = (state_reg == LOAD);
  assign head      = mem[rd_ptr_reg];
  assign CMD_READY = (level_reg != (AW+1)'(QDEPTH));
  assign Q_LEVEL   = level_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= T_DATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop)      level_reg <= level_reg + (AW+1)'(1);
      else if (pop && !push) level_reg <= level_reg - (AW+1)'(1);
    end
  end

  // ---------------- frame engine ----------------
  logic [CW-1:0] cnt_reg;
  logic [6:0]    bit_idx_reg;   // index of the bit on the line, preamble included
  logic [31:0]   sreg_reg;
  logic [15:0]   cap_reg;
  logic          is_read_reg;
  logic          mdc_reg, oe_reg, out_reg, rdy_reg;
  logic [15:0]   rd_data_reg;

  logic [6:0]  nxt_idx;
  logic [31:0] sreg_sh;

  assign nxt_idx = bit_idx_reg + 7'd1;
  // The shift register only advances once frame bits are being sent. During
  // the preamble its MSB stays parked for the first header bit.
  assign sreg_sh = (int'(bit_idx_reg) >= PRE_LEN) ? {sreg_reg[30:0], 1'b0} : sreg_reg;

  function automatic state_t phase_of(input logic [6:0] n);
    int v;
    v = int'(n);
    if (v < PRE_LEN)           return PRE;
    else if (v < PRE_LEN + 14) return HDR;
    else if (v < PRE_LEN + 16) return TA;
    else if (v < PRE_LEN + 32) return DATA;
    else                       return DONE;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      sreg_reg    <= '0;
      cap_reg     <= '0;
      is_read_reg <= 1'b0;
      mdc_reg     <= 1'b0;
      oe_reg      <= 1'b0;
      out_reg     <= 1'b0;
      rdy_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      rdy_reg <= 1'b0;
      case (state_reg)
        IDLE: if (level_reg != '0) state_reg <= LOAD;
        LOAD: begin
          sreg_reg    <= head;
          is_read_reg <= head[29];
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
          mdc_reg     <= 1'b0;
          oe_reg      <= 1'b1;
          out_reg     <= (PRE_LEN > 0) ? 1'b1 : head[31];
          state_reg   <= phase_of(7'd0);
        end
        DONE: state_reg <= IDLE;
        default: begin
          // Rising MDC mid-bit; this is also the read sampling point.
          if (cnt_reg == HALF) begin
            mdc_reg <= 1'b1;
            if (state_reg == DATA) cap_reg <= {cap_reg[14:0], MDIO_IN};
          end
          if (cnt_reg == FULL) begin
            // Falling MDC: move to the next bit.
            cnt_reg     <= '0;
            mdc_reg     <= 1'b0;
            bit_idx_reg <= nxt_idx;
            sreg_reg    <= sreg_sh;
            out_reg     <= (int'(nxt_idx) < PRE_LEN) ? 1'b1 : sreg_sh[31];
            state_reg   <= phase_of(nxt_idx);
            if (int'(nxt_idx) == PRE_LEN + 32) begin
              oe_reg <= 1'b0;
              if (is_read_reg) begin
                rd_data_reg <= cap_reg;
                rdy_reg     <= 1'b1;
              end
            end else if (is_read_reg && int'(nxt_idx) >= PRE_LEN + 14) begin
              oe_reg <= 1'b0;   // the PHY owns the line from turnaround onward
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      endcase
    end
  end

  assign BUSY     = (state_reg != IDLE);
  assign MDC      = mdc_reg;
  assign MDIO_OE  = oe_reg;
  assign MDIO_OUT = out_reg;
  assign RD_DATA  = rd_data_reg;
  assign DATA_RDY = rdy_reg;

endmodule

// File: tb/tb_mdio_master_gen.sv
`timescale 1ns/1ps
// Directed bench for mdio_master_gen.
// u0: DIV=2, PRE_LEN=32, QDEPTH=4 (write, read, queue, reset-in-frame).
// u1: DIV=1, PRE_LEN=0 (Clause 45 address and read frames).
module tb_mdio_master_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr;
  logic [31:0] td0, td1;
  logic st0, st1, mi0, mi1;
  logic rdy0, rdy1, busy0, busy1, drdy0, drdy1, mdc0, mdc1, oe0, oe1, mo0, mo1;
  logic [2:0] lvl0, lvl1;
  logic [15:0] rd0, rd1, resp0, resp1;

  mdio_master_gen #(.DIV(2), .PRE_LEN(32), .QDEPTH(4)) u0 (
    .clk(clk), .rst(rst), .T_DATA(td0), .MDIO_START(st0), .CMD_READY(rdy0),
    .Q_LEVEL(lvl0), .BUSY(busy0), .MDIO_IN(mi0), .RD_DATA(rd0), .DATA_RDY(drdy0),
    .MDC(mdc0), .MDIO_OE(oe0), .MDIO_OUT(mo0));

  mdio_master_gen #(.DIV(1), .PRE_LEN(0), .QDEPTH(4)) u1 (
    .clk(clk), .rst(rst), .T_DATA(td1), .MDIO_START(st1), .CMD_READY(rdy1),
    .Q_LEVEL(lvl1), .BUSY(busy1), .MDIO_IN(mi1), .RD_DATA(rd1), .DATA_RDY(drdy1),
    .MDC(mdc1), .MDIO_OE(oe1), .MDIO_OUT(mo1));

  int tests = 0, fails = 0;

  // ---------------- line monitors and PHY responders ----------------
  int rise0c, busy0c, oe0c, rdy0c, bitn0;
  int rise1c, busy1c, oe1c, rdy1c, bitn1;
  logic [63:0] bits0, oeb0, bits1, oeb1;
  logic mdc0_p, oe0_p, busy0_p, mdc1_p, oe1_p, busy1_p;
  logic [31:0] frames0[$];

  // Responder drives read data on the DATA bits; bit numbers count from the first bit.
  assign mi0 = (bitn0 >= 48 && bitn0 < 64) ? resp0[4'(63 - bitn0)] : 1'b1;
  assign mi1 = (bitn1 >= 16 && bitn1 < 32) ? resp1[4'(31 - bitn1)] : 1'b1;

  always @(negedge clk) begin
    if (clr) begin
      rise0c = 0; busy0c = 0; oe0c = 0; rdy0c = 0; bitn0 = 0;
      bits0 = '0; oeb0 = '0; frames0.delete();
    end
    if (oe0 && !oe0_p)        bitn0 = 0;
    else if (!mdc0 && mdc0_p) bitn0++;
    if (mdc0 && !mdc0_p) begin
      rise0c++;
      bits0 = {bits0[62:0], mo0};
      oeb0  = {oeb0[62:0], oe0};
    end
    busy0c += int'(busy0); oe0c += int'(oe0); rdy0c += int'(drdy0);
    if (!busy0 && busy0_p) frames0.push_back(bits0[31:0]);
    mdc0_p = mdc0; oe0_p = oe0; busy0_p = busy0;
  end

  always @(negedge clk) begin
    if (clr) begin
      rise1c = 0; busy1c = 0; oe1c = 0; rdy1c = 0; bitn1 = 0;
      bits1 = '0; oeb1 = '0;
    end
    if (oe1 && !oe1_p)        bitn1 = 0;
    else if (!mdc1 && mdc1_p) bitn1++;
    if (mdc1 && !mdc1_p) begin
      rise1c++;
      bits1 = {bits1[62:0], mo1};
      oeb1  = {oeb1[62:0], oe1};
    end
    busy1c += int'(busy1); oe1c += int'(oe1); rdy1c += int'(drdy1);
    mdc1_p = mdc1; oe1_p = oe1; busy1_p = busy1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clear();
    @(posedge clk); clr = 1'b1;
    @(posedge clk); clr = 1'b0;
  endtask

  task automatic push0(input logic [31:0] d);
    @(negedge clk); td0 = d; st0 = 1'b1;
    @(negedge clk); st0 = 1'b0;
  endtask

  task automatic push1(input logic [31:0] d);
    @(negedge clk); td1 = d; st1 = 1'b1;
    @(negedge clk); st1 = 1'b0;
  endtask

  task automatic wait_idle0(input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy0 || lvl0 != 3'd0) && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) check("timeout_u0", 64'(n), 64'(0));
    #1;
  endtask

  task automatic wait_idle1(input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy1 || lvl1 != 3'd0) && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) check("timeout_u1", 64'(n), 64'(0));
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] qv [6];
  logic [31:0] c45a, c45r;
  initial begin
    int n;
    rst = 1'b1; clr = 1'b0; st0 = 1'b0; st1 = 1'b0; td0 = '0; td1 = '0;
    resp0 = '0; resp1 = '0;
    mdc0_p = 1'b0; oe0_p = 1'b0; busy0_p = 1'b0;
    mdc1_p = 1'b0; oe1_p = 1'b0; busy1_p = 1'b0;
    qv[0] = 32'h5000_0001; qv[1] = 32'h5123_4567; qv[2] = 32'h5089_ABCD;
    qv[3] = 32'h5FFF_0000; qv[4] = 32'h5555_AAAA; qv[5] = 32'h5EAD_BEEF;
    c45a = {2'b00, 2'b00, 5'd3, 5'd1, 2'b10, 16'h0005};
    c45r = {2'b00, 2'b11, 5'd3, 5'd1, 2'b10, 16'h0000};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags_u0", {mdc0, oe0, mo0, drdy0, busy0, rdy0}, 6'b000001);
    check("rst_level_u0", lvl0, 3'd0);
    check("rst_rddata_u0", rd0, 16'h0000);
    check("rst_flags_u1", {mdc1, oe1, mo1, drdy1, busy1, rdy1, lvl1}, 9'b000001_000);
    @(negedge clk); rst = 1'b0;

    // Write frame with accept-to-first-bit timing.
    clear();
    push0(32'h508AA5C3);
    check("acc_level", lvl0, 3'd1);
    check("acc_busy", busy0, 1'b0);
    @(negedge clk);
    check("load_busy_oe", {busy0, oe0}, 2'b10);
    @(negedge clk);
    check("first_bit", {oe0, mo0, mdc0}, 3'b110);
    wait_idle0(2000);
    check("wr_bits", bits0, {32'hFFFF_FFFF, 32'h508AA5C3});
    check("wr_rises", 64'(rise0c), 64'd64);
    check("wr_oe_clk", 64'(oe0c), 64'd256);
    check("wr_busy_clk", 64'(busy0c), 64'd258);
    check("wr_no_rdy", 64'(rdy0c), 64'd0);

    // Read frame, PHY answers 0xBEEF.
    clear();
    resp0 = 16'hBEEF;
    push0(32'h6190_0000);
    wait_idle0(2000);
    check("rd_data", rd0, 16'hBEEF);
    check("rd_pulses", 64'(rdy0c), 64'd1);
    check("rd_oe_per_bit", oeb0, 64'hFFFF_FFFF_FFFC_0000);
    check("rd_header", bits0 >> 18, {32'hFFFF_FFFF, 32'h6190_0000} >> 18);
    check("rd_oe_clk", 64'(oe0c), 64'd184);

    // Queue: six back-to-back pushes, sixth dropped.
    clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); td0 = qv[i]; st0 = 1'b1;
    end
    @(negedge clk); st0 = 1'b0;
    check("q_full_level", lvl0, 3'd4);
    check("q_full_ready", rdy0, 1'b0);
    wait_idle0(8000);
    check("q_frames", 64'(frames0.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < frames0.size()) check($sformatf("q_frame%0d", i), frames0[i], qv[i]);

    // Reset during DATA of a read with two writes queued.
    clear();
    resp0 = 16'hCAFE;
    push0(32'h6190_0000);
    push0(qv[1]);
    push0(qv[2]);
    n = 0;
    while (!(busy0 && bitn0 >= 52) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check("timeout_rstwait", 64'(n), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_flags", {mdc0, oe0, mo0, drdy0, busy0, rdy0}, 6'b000001);
    check("midrst_level", lvl0, 3'd0);
    check("midrst_rddata", rd0, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    check("midrst_no_rdy", 64'(rdy0c), 64'd0);
    check("midrst_idle", {busy0, lvl0}, 4'b0000);

    // DIV=1, no preamble: C45 address then C45 read.
    clear();
    resp1 = 16'h1234;
    push1(c45a);
    wait_idle1(500);
    check("c45a_busy_clk", 64'(busy1c), 64'd66);
    check("c45a_oe_clk", 64'(oe1c), 64'd64);
    check("c45a_bits", bits1[31:0], c45a);
    check("c45a_no_rdy", 64'(rdy1c), 64'd0);
    clear();
    push1(c45r);
    wait_idle1(500);
    check("c45r_busy_clk", 64'(busy1c), 64'd66);
    check("c45r_rises", 64'(rise1c), 64'd32);
    check("c45r_oe_per_bit", oeb1[31:0], 32'hFFFC_0000);
    check("c45r_header", bits1[31:18], c45r[31:18]);
    check("c45r_pulses", 64'(rdy1c), 64'd1);
    check("c45r_data", rd1, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdio_master_gen.md
# mdio_master_gen

Parametrised MDIO management master: accepts 32-bit management frames into a command queue, generates MDC from the system clock, serialises preamble and frame onto MDIO, releases the line for read turnaround and captures the 16-bit read data. It is the next-generation MDIO generator/transmitter of the station-management path, adding a programmable MDC divider, a programmable preamble length, a command queue, and Clause 45 opcodes.

## Interface
- DIV, 2: MDC half-period in clk cycles (≥1); one MDIO bit = 2*DIV clk.
- PRE_LEN, 32: preamble bits of '1' before each frame (0..32).
- QDEPTH, 4: command queue depth (power of 2, ≥2).
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- T_DATA  in  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD/PRTAD, [22:18] REGAD/DEVAD, [17:16] TA, [15:0] write data/address (ignored for reads).
- MDIO_START  in  1  push strobe; T_DATA enqueued when MDIO_START & CMD_READY.
- CMD_READY  out  1  queue not full.
- Q_LEVEL  out  $clog2(QDEPTH)+1  queue occupancy.
- BUSY  out  1  frame in progress (state ≠ IDLE).
- MDIO_IN  in  1  MDIO pad input.
- RD_DATA  out  16  last completed read data.
- DATA_RDY  out  1  one-clk pulse when RD_DATA updated.
- MDC  out  1  management clock.
- MDIO_OE  out  1  MDIO pad output enable.
- MDIO_OUT  out  1  MDIO pad output data.

## Operation
- Reset values: MDC=0, MDIO_OE=0, MDIO_OUT=0, RD_DATA=0, DATA_RDY=0, BUSY=0, CMD_READY=1, Q_LEVEL=0; queue flushed, state IDLE.
- Queue: FIFO, QDEPTH entries. Push while full dropped (no state change). Push and pop in same cycle allowed; level unchanged.
- Read frame: OP[1]=1 (10 = C22 read / C45 post-read-increment, 11 = C45 read). Otherwise write (01 write, 00 C45 address). ST not interpreted.
- States: IDLE -> (queue non-empty) LOAD: pop into 32-bit shift register -> PRE (PRE_LEN bits; skipped if 0) -> HDR (14 bits: ST,OP,addr) -> TA (2) -> DATA (16) -> DONE (1 clk) -> IDLE.
- Bit drive: MDIO_OUT changes only at MDC falling edges (and at frame start); MSB first, preamble bits = 1.
- Write: MDIO_OE=1 across PRE, HDR, TA, DATA; TA/data bits taken from T_DATA.
- Read: MDIO_OE=1 across PRE and HDR; 0 from start of TA until IDLE. MDIO_IN sampled on clk edge where MDC goes 0->1, during DATA only, into a capture shifter.
- DONE: reads copy capture shifter to RD_DATA and pulse DATA_RDY; writes produce no pulse. RD_DATA otherwise holds.
- MDC is low in IDLE, LOAD, DONE; toggles every DIV clk while in PRE..DATA.

## Timing
- Accept at edge t into an empty queue while IDLE: LOAD at t+1, first bit driven with MDIO_OE=1 at t+2.
- Each bit: MDC low DIV clk, then high DIV clk; rising edge mid-bit.
- Frame (first bit to MDIO_OE fall for writes): (PRE_LEN+32)*2*DIV clk. DATA_RDY asserted the cycle after the final MDC falling edge.
- Back-to-back: next frame LOAD follows DONE -> IDLE; 3 clk gap with MDC low between frames.
- Reset mid-frame: all outputs return to reset values asynchronously; in-flight and queued frames discarded; no DATA_RDY.
- MDIO_IN requires no synchroniser inside block (pad sync external).

## Test plan
- Reset: rst high 3 clk -> all outputs at reset values, CMD_READY=1, Q_LEVEL=0.
- Write, DIV=2, PRE_LEN=32, T_DATA=0x508AA5C3 -> 32 ones then 0x508AA5C3 MSB-first at MDC rising edges, MDIO_OE high 256 clk, no DATA_RDY.
- Read, T_DATA=0x61900000, responder drives 0xBEEF MSB-first on DATA bits -> MDIO_OE falls at bit 47 (after 46 bits), one DATA_RDY pulse, RD_DATA=0xBEEF.
- Queue, QDEPTH=4: six consecutive pushes while idle -> first popped immediately, next four queued, sixth dropped, CMD_READY=0 with Q_LEVEL=4; five frames emitted in order.
- Reset asserted during DATA of a read with two commands queued -> outputs at reset values immediately, Q_LEVEL=0, no DATA_RDY, RD_DATA=0.
- DIV=1, PRE_LEN=0, C45 address then C45 read (ST=00, OP=00 then 11) -> each frame 64 clk, no preamble, read pulses DATA_RDY, write does not.
